// File: rtl/branch_ctrl_if.sv
// Decoder/ALU-side bundle for branch_ctrl: instruction and flag inputs,
// PC load requests, squash and the debug view of the target register.
interface branch_ctrl_if #(
    parameter int D = 8
);
    logic         instr_valid;
    logic [2:0]   op;
    logic [3:0]   imm;
    logic         flag_we;
    logic         alu_zero;
    logic         alu_neg;
    logic [D-1:0] prog_ctr;
    logic         jump_en;
    logic         branch_en;
    logic [D-1:0] target;
    logic         squash;
    logic [D-1:0] tgt_dbg;

    modport master (
        output instr_valid, op, imm, flag_we, alu_zero, alu_neg, prog_ctr,
        input  jump_en, branch_en, target, squash, tgt_dbg
    );

    modport slave (
        input  instr_valid, op, imm, flag_we, alu_zero, alu_neg, prog_ctr,
        output jump_en, branch_en, target, squash, tgt_dbg
    );
endinterface

// File: rtl/branch_ctrl.sv
// branch_ctrl: jump target assembly, Z/N flags, jump/branch resolution and 2-cycle squash.
// Macro BRANCH_REL_EN: conditional branches use prog_ctr + tgt_reg; undefined = absolute tgt_reg.
module branch_ctrl #(
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         reset,
    branch_ctrl_if.slave bus
);
    // state     | meaning
    // S_IDLE    | accepting instructions, no transfer pending
    // S_TAKEN_J | jump_en high, first wrong-path slot squashed
    // S_TAKEN_B | branch_en high, first wrong-path slot squashed
    // S_SQUASH2 | second wrong-path slot squashed
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TAKEN_J = 2'd1,
        S_TAKEN_B = 2'd2,
        S_SQUASH2 = 2'd3
    } state_t;

    localparam logic [2:0] OP_SETLO = 3'd1;
    localparam logic [2:0] OP_SETHI = 3'd2;
    localparam logic [2:0] OP_JMP   = 3'd3;
    localparam logic [2:0] OP_BEQ   = 3'd4;
    localparam logic [2:0] OP_BNE   = 3'd5;
    localparam logic [2:0] OP_BLT   = 3'd6;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [D-1:0] r_tgt_reg;
    logic [D-1:0] w_tgt_reg_nxt;
    logic [D-1:0] r_target;
    logic [D-1:0] w_target_nxt;
    logic [D-1:0] w_br_target;
    logic [D-5:0] w_hi_ext;
    logic         r_z_flag;
    logic         r_n_flag;
    logic         w_z_nxt;
    logic         w_n_nxt;
    logic         r_jump_en;
    logic         r_branch_en;
    logic         r_squash;
    logic         w_jump_nxt;
    logic         w_branch_nxt;
    logic         w_squash_nxt;
    logic         w_accept;
    logic         w_taken;

`ifdef BRANCH_REL_EN
    assign w_br_target = bus.prog_ctr + r_tgt_reg;
`else
    assign w_br_target = r_tgt_reg;
`endif

    // SETHI fills bits [D-1:4]: the nibble itself plus its sign above bit 7
    assign w_hi_ext = (D-4)'(signed'(bus.imm));
    assign w_accept = bus.instr_valid & ~r_squash;

    always_comb begin
        w_taken = 1'b0;
        case (bus.op)
            OP_JMP:  w_taken = 1'b1;
            OP_BEQ:  w_taken = r_z_flag;
            OP_BNE:  w_taken = ~r_z_flag;
            OP_BLT:  w_taken = r_n_flag;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tgt_reg_nxt = r_tgt_reg;
        w_target_nxt  = r_target;
        w_z_nxt       = r_z_flag;
        w_n_nxt       = r_n_flag;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (bus.op == OP_SETLO) begin
                        w_tgt_reg_nxt = {r_tgt_reg[D-1:4], bus.imm};
                    end else if (bus.op == OP_SETHI) begin
                        w_tgt_reg_nxt = {w_hi_ext, r_tgt_reg[3:0]};
                    end
                    if (bus.flag_we) begin
                        w_z_nxt = bus.alu_zero;
                        w_n_nxt = bus.alu_neg;
                    end
                    // branch condition above already used the pre-write flags
                    if (w_taken) begin
                        if (bus.op == OP_JMP) begin
                            w_state_nxt  = S_TAKEN_J;
                            w_target_nxt = r_tgt_reg;
                        end else begin
                            w_state_nxt  = S_TAKEN_B;
                            w_target_nxt = w_br_target;
                        end
                    end
                end
            end
            S_TAKEN_J: w_state_nxt = S_SQUASH2;
            S_TAKEN_B: w_state_nxt = S_SQUASH2;
            S_SQUASH2: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
        w_jump_nxt   = (w_state_nxt == S_TAKEN_J);
        w_branch_nxt = (w_state_nxt == S_TAKEN_B);
        w_squash_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_tgt_reg   <= '0;
            r_target    <= '0;
            r_z_flag    <= 1'b0;
            r_n_flag    <= 1'b0;
            r_jump_en   <= 1'b0;
            r_branch_en <= 1'b0;
            r_squash    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tgt_reg   <= w_tgt_reg_nxt;
            r_target    <= w_target_nxt;
            r_z_flag    <= w_z_nxt;
            r_n_flag    <= w_n_nxt;
            r_jump_en   <= w_jump_nxt;
            r_branch_en <= w_branch_nxt;
            r_squash    <= w_squash_nxt;
        end
    end

    assign bus.jump_en   = r_jump_en;
    assign bus.branch_en = r_branch_en;
    assign bus.target    = r_target;
    assign bus.squash    = r_squash;
    assign bus.tgt_dbg   = r_tgt_reg;
endmodule
